// File: rtl/piso_pkg.sv
// piso_pkg: shared definitions for the framed PISO transmitter.
//   state_t        - transmitter FSM states
//   DEFAULT_N      - default data bits per frame
//   DEFAULT_IDLE_LEVEL - default idle/stop line level
//   count_width()  - bit-counter width for a given frame size
package piso_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
    STOP
  } state_t;

  localparam int unsigned DEFAULT_N          = 4;
  localparam logic        DEFAULT_IDLE_LEVEL = 1'b1;

  // Wide enough to hold 0..N so the counter never wraps inside a frame.
  function automatic int unsigned count_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_shift.sv
// piso_shift: N-bit load/shift register presenting the next bit to transmit.
//   clk, rst  - clock, asynchronous active-high reset (clears register)
//   load      - capture d (has priority over shift)
//   shift     - advance one bit toward the head
//   d         - parallel word
//   head      - bit currently at the head (q[0] LSB-first, q[N-1] MSB-first)
module piso_shift #(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] d,
  output logic         head
);

  logic [N-1:0] q;
  logic [N-1:0] q_shifted;

  generate
    if (N == 1) begin : g_single
      always_comb q_shifted = '0;
    end else if (MSB_FIRST) begin : g_msb
      always_comb q_shifted = {q[N-2:0], 1'b0};
    end else begin : g_lsb
      always_comb q_shifted = {1'b0, q[N-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= q_shifted;
    end
  end

  assign head = MSB_FIRST ? q[N-1] : q[0];

endmodule

// File: rtl/piso_frame_tx.sv
// piso_frame_tx: framed parallel-in/serial-out transmitter.
// Accepts an N-bit word over VALID/READY and sends start bit, N data bits
// and stop bit, one bit per CE tick.
//   CLK    - clock (rising edge)
//   RESET  - asynchronous active-high reset; aborts any frame in flight
//   I      - parallel word, sampled on the accept edge only
//   VALID  - upstream word available
//   READY  - high only while idle
//   CE     - bit-rate tick
//   O      - registered serial line
//   BUSY   - high whenever not idle
//   DONE   - one-cycle pulse after the stop bit completes
module piso_frame_tx
  import piso_pkg::*;
#(
  parameter int unsigned N          = DEFAULT_N,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter logic        IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [N-1:0] I,
  input  logic         VALID,
  output logic         READY,
  input  logic         CE,
  output logic         O,
  output logic         BUSY,
  output logic         DONE
);

  localparam int unsigned       CW   = count_width(N);
  localparam logic [CW-1:0]     LAST = CW'(N - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            o_q, o_nxt;
  logic            done_q, done_nxt;
  logic            load, shift;
  logic            head;

  piso_shift #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk   (CLK),
    .rst   (RESET),
    .load  (load),
    .shift (shift),
    .d     (I),
    .head  (head)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      count  <= '0;
      o_q    <= IDLE_LEVEL;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      o_q    <= o_nxt;
      done_q <= done_nxt;
    end
  end

  // Each data bit is driven from the register head while the register
  // advances on the same edge, so the head always holds the next bit due.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    o_nxt     = o_q;
    done_nxt  = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;

    case (state)
      IDLE: begin
        o_nxt = IDLE_LEVEL;
        // CE is deliberately ignored here, including on the accept edge.
        if (VALID) begin
          load      = 1'b1;
          count_nxt = '0;
          state_nxt = ARM;
        end
      end
      ARM: begin
        if (CE) begin
          o_nxt     = ~IDLE_LEVEL;
          state_nxt = START;
        end
      end
      START: begin
        if (CE) begin
          o_nxt     = head;
          shift     = 1'b1;
          count_nxt = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (CE) begin
          if (count == LAST) begin
            o_nxt     = IDLE_LEVEL;
            state_nxt = STOP;
          end else begin
            o_nxt     = head;
            shift     = 1'b1;
            count_nxt = count + 1'b1;
          end
        end
      end
      STOP: begin
        if (CE) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        o_nxt     = IDLE_LEVEL;
        state_nxt = IDLE;
      end
    endcase
  end

  assign O     = o_q;
  assign DONE  = done_q;
  assign READY = (state == IDLE);
  assign BUSY  = (state != IDLE);

endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: an LSB-first and an MSB-first instance share all
// stimulus; a queue-based line model predicts O/READY/BUSY/DONE per cycle.
module tb_piso_frame_tx;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       VALID;
  logic       CE;
  logic [3:0] I;
  logic       O_l, READY_l, BUSY_l, DONE_l;
  logic       O_m, READY_m, BUSY_m, DONE_m;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  piso_frame_tx #(.N(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .CLK(CLK), .RESET(RESET), .I(I), .VALID(VALID), .READY(READY_l),
    .CE(CE), .O(O_l), .BUSY(BUSY_l), .DONE(DONE_l)
  );

  piso_frame_tx #(.N(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb (
    .CLK(CLK), .RESET(RESET), .I(I), .VALID(VALID), .READY(READY_m),
    .CE(CE), .O(O_m), .BUSY(BUSY_m), .DONE(DONE_m)
  );

  always #5 CLK = ~CLK;

  // Line model: a frame is a list of line levels to emit, one per CE tick,
  // terminated by a marker (2) meaning "back to idle with DONE".
  int   q_l[$];
  int   q_m[$];
  bit   m_busy;
  logic m_o_l, m_o_m, m_done;

  task automatic model_reset();
    q_l.delete();
    q_m.delete();
    m_busy = 1'b0;
    m_o_l  = 1'b1;
    m_o_m  = 1'b1;
    m_done = 1'b0;
  endtask

  task automatic model_edge();
    int x_l, x_m;
    if (RESET) begin
      model_reset();
      return;
    end
    m_done = 1'b0;
    if (!m_busy) begin
      if (VALID) begin
        q_l = '{0};
        q_m = '{0};
        for (int b = 0; b < 4; b++) begin
          q_l.push_back(int'(I[b]));
          q_m.push_back(int'(I[3-b]));
        end
        q_l.push_back(1); q_l.push_back(2);
        q_m.push_back(1); q_m.push_back(2);
        m_busy = 1'b1;
      end
    end else if (CE) begin
      x_l = q_l.pop_front();
      x_m = q_m.pop_front();
      if (x_l == 2) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end else begin
        m_o_l = x_l[0];
        m_o_m = x_m[0];
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("o_lsb", O_l, m_o_l);
    check("o_msb", O_m, m_o_m);
    check("ready", READY_l, !m_busy);
    check("busy", BUSY_l, m_busy);
    check("done_lsb", DONE_l, m_done);
    check("done_msb", DONE_m, m_done);
  endtask

  // One clock: the model consumes the inputs present at the edge, outputs
  // are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  int seq1[6]  = '{0, 1, 1, 0, 1, 1};
  int spat[6]  = '{0, 1, 0, 1, 0, 1};
  int w9[4]    = '{1, 0, 0, 1};
  int w5[4]    = '{1, 0, 1, 0};
  int n_done;
  int n_ready;

  initial begin
    RESET = 1'b1; VALID = 1'b0; CE = 1'b0; I = '0;
    model_reset();
    repeat (2) tick();
    RESET = 1'b0;

    // warm-up traffic
    for (int k = 0; k < 40; k++) begin
      VALID = ($urandom_range(0, 3) == 0);
      I     = 4'($urandom);
      CE    = ($urandom_range(0, 1) == 1);
      tick();
    end

    // reset between edges, then quiet idle
    #2 RESET = 1'b1;
    #1;
    model_reset();
    check("rst_async_o", O_l, 1'b1);
    check("rst_async_busy", BUSY_l, 1'b0);
    tick();
    RESET = 1'b0; VALID = 1'b0;
    for (int k = 0; k < 20; k++) begin
      CE = ($urandom_range(0, 1) == 1);
      tick();
      check("idle_o", O_l, 1'b1);
      check("idle_ready", READY_l, 1'b1);
    end

    // single frame, CE high, I=1011 LSB-first
    I = 4'b1011; VALID = 1'b1; CE = 1'b1;
    tick();
    VALID = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k <= 6) check("single_line", O_l, 8'(seq1[k-1]));
      if (k == 6) check("single_done_early", DONE_l, 1'b0);
    end
    check("single_done_e7", DONE_l, 1'b1);
    check("single_ready_e7", READY_l, 1'b1);
    tick();

    // sparse CE every 5th cycle, I=A, MSB-first instance
    I = 4'hA; VALID = 1'b1; CE = 1'b0;
    tick();
    VALID = 1'b0;
    n_done = 0;
    for (int k = 1; k <= 37; k++) begin
      CE = (k % 5 == 0);
      tick();
      if (k >= 5 && k < 35) check("sparse_line", O_m, 8'(spat[(k-5)/5]));
      if (k == 35) check("sparse_done_e35", DONE_m, 1'b1);
      if (DONE_m) n_done++;
    end
    check("sparse_done_count", 8'(n_done), 8'd1);

    // busy rejection: VALID held, I changes mid-frame
    I = 4'h9; VALID = 1'b1; CE = 1'b1;
    tick();
    for (int k = 1; k <= 16; k++) begin
      if (k == 4) I = 4'h5;
      if (k == 9) VALID = 1'b0;
      tick();
      if (k >= 2 && k <= 5) check("busy_word1", O_l, 8'(w9[k-2]));
      if (k == 8) check("busy_accept2", BUSY_l, 1'b1);
      if (k >= 10 && k <= 13) check("busy_word2", O_l, 8'(w5[k-10]));
    end

    // back-to-back frames with VALID held
    I = 4'h3; VALID = 1'b1; CE = 1'b1;
    tick();
    I = 4'hC;
    n_done = 0; n_ready = 0;
    for (int k = 1; k <= 17; k++) begin
      if (k == 9) VALID = 1'b0;
      tick();
      if (DONE_l) n_done++;
      if (k <= 14 && READY_l) n_ready++;
    end
    check("b2b_done_count", 8'(n_done), 8'd2);
    check("b2b_idle_gap", 8'(n_ready), 8'd1);

    // reset during data bit 2
    I = 4'h6; VALID = 1'b1; CE = 1'b1;
    tick();
    VALID = 1'b0;
    repeat (4) tick();
    #2 RESET = 1'b1;
    #1;
    model_reset();
    check("midrst_o", O_l, 1'b1);
    check("midrst_done", DONE_l, 1'b0);
    check("midrst_ready", READY_l, 1'b1);
    repeat (2) tick();
    RESET = 1'b0;
    tick();
    I = 4'hD; VALID = 1'b1;
    tick();
    VALID = 1'b0;
    repeat (9) tick();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      VALID = ($urandom_range(0, 2) == 0);
      I     = 4'($urandom);
      CE    = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
